// File: rtl/ntt_result_collector_pkg.sv
// Shared constants and FSM encoding for the NTT1024 result collector.
package ntt_result_collector_pkg;
  localparam int COLL_DATA_W    = 32;
  localparam int COLL_MAX_DEPTH = 10;
  localparam int COLL_PE_DEPTH  = 0;
  localparam int COLL_RING_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_SKIP      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DRAIN     = 3'd4
  } coll_state_e;
endpackage

// File: rtl/ntt_result_collector_if.sv
// Control, capture and output-stream signals of the result collector.
interface ntt_result_collector_if
  import ntt_result_collector_pkg::*;
#(
  parameter int DATA_W    = COLL_DATA_W,
  parameter int MAX_DEPTH = COLL_MAX_DEPTH
);
  logic                   start;
  logic [COLL_RING_W-1:0] ring_size;
  logic [DATA_W-1:0]      q;
  logic                   core_done;
  logic [DATA_W-1:0]      core_dout;
  logic [DATA_W-1:0]      out_data;
  logic [MAX_DEPTH-1:0]   out_index;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   error;

  modport slave (
    input  start, ring_size, q, core_done, core_dout, out_ready,
    output out_data, out_index, out_valid, out_last, busy, error
  );
  modport master (
    output start, ring_size, q, core_done, core_dout, out_ready,
    input  out_data, out_index, out_valid, out_last, busy, error
  );
endinterface

// File: rtl/ntt_result_collector_ram.sv
// Simple dual-port buffer: one write port, one synchronous read port that holds when not enabled.
module ntt_collect_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ntt_result_collector.sv
// Captures zero-delimited NTT1024 bursts, de-interleaves them into a buffer, then streams
// the n coefficients in natural order reduced to [0,q) over a valid/ready interface.
module ntt_result_collector
  import ntt_result_collector_pkg::*;
#(
  parameter int DATA_W    = COLL_DATA_W,
  parameter int MAX_DEPTH = COLL_MAX_DEPTH,
  parameter int PE_DEPTH  = COLL_PE_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  ntt_result_collector_if.slave bus
);
  localparam int NW = MAX_DEPTH + 1;

  coll_state_e r_state, w_state_nxt;

  logic [NW-1:0]        r_n, r_m, r_b, r_rd_ptr;
  logic [DATA_W-1:0]    r_q;
  logic                 r_s1_vld;
  logic [MAX_DEPTH-1:0] r_s1_idx;
  logic [DATA_W-1:0]    r_out_data;
  logic [MAX_DEPTH-1:0] r_out_index;
  logic                 r_out_valid, r_out_last, r_error;

  logic                 w_start_acc, w_nz, w_cap, w_wr, w_burst_end, w_cap_done;
  logic                 w_out_adv, w_rd, w_fire_last;
  logic [NW-1:0]        w_bursts, w_b_inc, w_n_m1;
  logic [MAX_DEPTH-1:0] w_half, w_waddr;
  logic [DATA_W-1:0]    w_rdata, w_red;
  logic                 w_unused;

  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_nz        = (bus.core_dout != '0);
  assign w_cap       = (r_state == ST_CAPTURE);
  assign w_wr        = w_cap && w_nz && (r_m < r_n);
  assign w_burst_end = w_cap && !w_nz;
  assign w_bursts    = r_n >> (PE_DEPTH + 1);
  assign w_b_inc     = r_b + 1'b1;
  // ">=" rather than "==" so a degenerate zero burst target still terminates on the first delimiter
  assign w_cap_done  = w_burst_end && (w_b_inc >= w_bursts);
  assign w_half      = r_n[NW-1:1];
  assign w_waddr     = r_m[0] ? (r_m[NW-1:1] + w_half) : r_m[NW-1:1];
  assign w_n_m1      = r_n - 1'b1;
  assign w_unused    = ^bus.ring_size[COLL_RING_W-1:NW];

  // Two-stage read pipeline: RAM output (s1) then the output register; a stage advances
  // whenever the one downstream of it frees up, so ready=1 gives one beat per cycle.
  assign w_out_adv   = !r_out_valid || bus.out_ready;
  assign w_rd        = (r_state == ST_DRAIN) && (r_rd_ptr < r_n) && (!r_s1_vld || w_out_adv);
  assign w_fire_last = r_out_valid && bus.out_ready && r_out_last;
  assign w_red       = (w_rdata >= r_q) ? (w_rdata - r_q) : w_rdata;

  ntt_collect_ram #(.DATA_W(DATA_W), .ADDR_W(MAX_DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr),
    .i_waddr (w_waddr),
    .i_wdata (bus.core_dout),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr[MAX_DEPTH-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (bus.start)     w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.core_done) w_state_nxt = ST_SKIP;
      ST_SKIP:                         w_state_nxt = ST_CAPTURE;
      ST_CAPTURE:   if (w_cap_done)    w_state_nxt = ST_DRAIN;
      ST_DRAIN:     if (w_fire_last)   w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_b         <= '0;
      r_rd_ptr    <= '0;
      r_error     <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_idx    <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_n      <= bus.ring_size[NW-1:0];
        r_q      <= bus.q;
        r_m      <= '0;
        r_b      <= '0;
        r_rd_ptr <= '0;
        r_error  <= 1'b0;
        r_s1_vld <= 1'b0;
      end
      if (w_wr) r_m <= r_m + 1'b1;
      if (w_cap && w_nz && !(r_m < r_n)) r_error <= 1'b1;
      if (w_burst_end) r_b <= w_b_inc;
      if (w_cap_done && (r_m != r_n)) r_error <= 1'b1;

      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_s1_vld <= 1'b1;
        r_s1_idx <= r_rd_ptr[MAX_DEPTH-1:0];
      end else if (w_out_adv) begin
        r_s1_vld <= 1'b0;
      end

      if (w_fire_last) begin
        r_out_valid <= 1'b0;
      end else if (w_out_adv) begin
        r_out_valid <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_data  <= w_red;
          r_out_index <= r_s1_idx;
          r_out_last  <= ({1'b0, r_s1_idx} == w_n_m1);
        end
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.error     = r_error;
endmodule

// File: tb/tb_ntt_result_collector.sv
// Directed bench for ntt_result_collector: n=256 Kyber runs, reduction, backpressure,
// word-count errors, mid-capture reset and ignored start/core_done.
module tb_ntt_result_collector;
  localparam int DW = 32;
  localparam int MD = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_result_collector_if #(.DATA_W(DW), .MAX_DEPTH(MD)) bus ();

  ntt_result_collector #(.DATA_W(DW), .MAX_DEPTH(MD), .PE_DEPTH(0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] stim [$];
  logic [31:0] exp_d [256];
  bit          exp_v [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] wv(input int m, input int mode);
    if (mode == 2 && m == 0) return 32'd3328;
    if (mode == 2 && m == 1) return 32'd3334;
    if (mode == 2 && m == 2) return 32'd6657;
    return 32'(m + 1);
  endfunction

  // 128 bursts: 2 words each, the final burst carries whatever remains of nwords.
  task automatic build(input int nwords, input int mode, input logic [31:0] q);
    int m = 0;
    stim.delete();
    foreach (exp_v[i]) exp_v[i] = 1'b0;
    for (int b = 0; b < 128; b++) begin
      int c = (b < 127) ? 2 : nwords - 254;
      for (int j = 0; j < c; j++) begin
        logic [31:0] w = wv(m, mode);
        stim.push_back(w);
        if (m < 256) begin
          int a = (m % 2 == 0) ? m / 2 : m / 2 + 128;
          exp_d[a] = (w >= q) ? w - q : w;
          exp_v[a] = 1'b1;
        end
        m++;
      end
      stim.push_back(32'd0);
    end
  endtask

  task automatic start_op(input int n, input logic [31:0] q);
    @(negedge clk);
    bus.start = 1'b1; bus.ring_size = 12'(n); bus.q = q;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_err_clr", 32'(bus.error), 32'd0);
  endtask

  task automatic play();
    @(negedge clk); bus.core_done = 1'b1;
    @(negedge clk); bus.core_done = 1'b0; bus.core_dout = 32'hDEAD;
    foreach (stim[i]) begin
      @(negedge clk); bus.core_dout = stim[i];
    end
  endtask

  task automatic drain(input bit rnd, input bit chk_lat, input bit exp_err);
    int k = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit rdy;
    logic [31:0] sd;
    logic [31:0] si;
    bus.out_ready = 1'b1;
    if (chk_lat) begin
      @(negedge clk); chk("lat0", 32'(bus.out_valid), 32'd0);
      @(negedge clk); chk("lat1", 32'(bus.out_valid), 32'd0);
    end
    while (k < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (chk_lat && cyc == 1) chk("lat2", 32'(bus.out_valid), 32'd1);
      if (stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", bus.out_data, sd);
        chk("stall_idx", 32'(bus.out_index), si);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      stall = bus.out_valid && !rdy;
      sd = bus.out_data;
      si = 32'(bus.out_index);
      if (bus.out_valid && rdy) begin
        chk("idx", 32'(bus.out_index), 32'(k));
        if (exp_v[k]) chk("data", bus.out_data, exp_d[k]);
        chk("last", 32'(bus.out_last), 32'(k == 255));
        k++;
      end
    end
    chk("beats", 32'(k), 32'd256);
    @(negedge clk);
    bus.out_ready = 1'b1;
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("valid_end", 32'(bus.out_valid), 32'd0);
    chk("error", 32'(bus.error), 32'(exp_err));
  endtask

  initial begin
    bus.start = 1'b0; bus.ring_size = '0; bus.q = '0;
    bus.core_done = 1'b0; bus.core_dout = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    rst_n = 1'b1;

    // core_done while idle must not start anything
    @(negedge clk); bus.core_done = 1'b1; bus.core_dout = 32'd5;
    @(negedge clk); bus.core_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_done_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_done_busy", 32'(bus.busy), 32'd0);
    bus.core_dout = '0;

    // Kyber baseline with first-beat latency
    build(256, 0, 32'd3329); start_op(256, 32'd3329); play(); drain(1'b0, 1'b1, 1'b0);

    // single-subtract reduction
    build(256, 2, 32'd3329); start_op(256, 32'd3329); play(); drain(1'b0, 1'b0, 1'b0);
    chk("red0", exp_d[0], 32'd3328);
    chk("red128", exp_d[128], 32'd5);

    // random backpressure
    build(256, 0, 32'd3329); start_op(256, 32'd3329); play(); drain(1'b1, 1'b0, 1'b0);

    // overflow then underflow
    build(257, 0, 32'd3329); start_op(256, 32'd3329); play(); drain(1'b0, 1'b0, 1'b1);
    build(255, 0, 32'd3329); start_op(256, 32'd3329); play(); drain(1'b1, 1'b0, 1'b1);

    // reset in the middle of capture
    build(256, 0, 32'd3329); start_op(256, 32'd3329);
    @(negedge clk); bus.core_done = 1'b1;
    @(negedge clk); bus.core_done = 1'b0; bus.core_dout = 32'hDEAD;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); bus.core_dout = stim[i];
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", bus.out_data, 32'd0);
    chk("mid_rst_index", 32'(bus.out_index), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_error", 32'(bus.error), 32'd0);
    rst_n = 1'b1; bus.core_dout = '0;

    // fresh run with a start pulse while busy (different n/q must be ignored)
    start_op(256, 32'd3329);
    @(negedge clk); bus.start = 1'b1; bus.ring_size = 12'd16; bus.q = 32'd5;
    @(negedge clk); bus.start = 1'b0; bus.ring_size = 12'd256; bus.q = 32'd3329;
    chk("busy_start_ign", 32'(bus.busy), 32'd1);
    play(); drain(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
